// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction fetch controller: steers the PC, fetches, buffers {pc, word} for decode
// Optional feature macro IFETCH_PERF_EN adds saturating stall/redirect/flush counters.
module ifetch_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int INSTR_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        pc,
  output logic               br,
  output logic [15:0]        br_add,
  output logic               jump,
  output logic [15:0]        jump_add,
  output logic               imem_req,
  output logic [15:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               cond_flag,
  input  logic               flush,
  input  logic [15:0]        flush_add,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [15:0]        instr_pc,
`ifdef IFETCH_PERF_EN
  output logic [15:0]        stall_cnt,
  output logic [15:0]        redirect_cnt,
  output logic [15:0]        flush_cnt,
`endif
  input  logic               id_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic {SYNC, RUN} state_t;

  state_t               state, state_nxt;
  logic [15:0]          exp_pc, exp_nxt;
  logic [15:0]          mem_pc [FIFO_DEPTH];
  logic [INSTR_W-1:0]   mem_w  [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop, room, taken, hold;
  logic [5:0]           opcode;
  logic [15:0]          beq_tgt;
  logic                 unused_bits;

  assign opcode      = imem_rdata[31:26];
  assign beq_tgt     = exp_pc + 16'd4 + {imem_rdata[13:0], 2'b00};
  assign jump_add    = imem_rdata[15:0];
  assign imem_addr   = exp_pc;
  assign instr_valid = (count != '0) && !reset;
  assign instr       = mem_w[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];
  assign unused_bits = ^imem_rdata;

  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign room = (count != FULL_CNT) || (instr_valid && id_ready);

  always_comb begin
    br        = 1'b0;
    br_add    = exp_pc;
    jump      = 1'b0;
    imem_req  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    taken     = 1'b0;
    hold      = 1'b0;
    state_nxt = state;
    exp_nxt   = exp_pc;
    if (reset) begin
      br     = 1'b1;
      br_add = '0;
    end else if (flush) begin
      br     = 1'b1;
      br_add = flush_add;
    end else begin
      pop = instr_valid && id_ready;
      if (state == SYNC) begin
        br        = 1'b1;
        state_nxt = RUN;
      end else if (pc != exp_pc) begin
        br        = 1'b1;
        hold      = 1'b1;
        state_nxt = SYNC;
      end else begin
        imem_req = room;
        if (room && imem_ready) begin
          push = 1'b1;
          if (opcode == OP_J) begin
            jump    = 1'b1;
            taken   = 1'b1;
            exp_nxt = imem_rdata[15:0];
          end else if (opcode == OP_BEQ && cond_flag) begin
            br      = 1'b1;
            br_add  = beq_tgt;
            taken   = 1'b1;
            exp_nxt = beq_tgt;
          end else begin
            exp_nxt = exp_pc + 16'd4;
          end
        end else begin
          br   = 1'b1;
          hold = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SYNC;
      exp_pc <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      state  <= SYNC;
      exp_pc <= flush_add;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      exp_pc <= exp_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr] <= exp_pc;
      mem_w[wr_ptr]  <= imem_rdata;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (hold && stall_cnt != 16'hFFFF)     stall_cnt    <= stall_cnt + 1'b1;
      if (taken && redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 1'b1;
      if (flush && flush_cnt != 16'hFFFF)    flush_cnt    <= flush_cnt + 1'b1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = hold ^ taken;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - randomized bench for ifetch_ctrl against a queue-based fetch model
module tb_ifetch_ctrl;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, cond_flag, flush, imem_ready, id_ready;
  logic [15:0] pc, flush_add;
  logic [31:0] imem_rdata;
  logic        br, jump, imem_req, instr_valid;
  logic [15:0] br_add, jump_add, imem_addr, instr_pc;
  logic [31:0] instr;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] p;
    logic [31:0] w;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_exp;
  bit          m_sync;

  logic        s_br, s_jump, s_req, s_valid;
  logic [15:0] s_br_add, s_jump_add, s_addr, s_ipc;
  logic [31:0] s_instr;

  ifetch_ctrl #(.FIFO_DEPTH(DEPTH), .INSTR_W(32)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .br(br), .br_add(br_add), .jump(jump), .jump_add(jump_add),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .cond_flag(cond_flag), .flush(flush), .flush_add(flush_add),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: expected PC, a sync flag and a queue of fetched entries.
  task automatic model_step();
    bit          e_br, e_jump, e_req, e_valid, pop, room;
    logic [15:0] e_badd, cur, tgt;
    logic [5:0]  op;
    cur     = m_exp;
    e_br    = 0;
    e_jump  = 0;
    e_req   = 0;
    e_badd  = cur;
    e_valid = !reset && q.size() > 0;
    chk("instr_valid", 32'(s_valid), 32'(e_valid));
    if (e_valid) begin
      chk("instr", s_instr, q[0].w);
      chk("instr_pc", 32'(s_ipc), 32'(q[0].p));
    end
    if (reset) begin
      e_br = 1; e_badd = 16'h0; m_exp = 16'h0; q.delete(); m_sync = 1;
    end else if (flush) begin
      e_br = 1; e_badd = flush_add; m_exp = flush_add; q.delete(); m_sync = 1;
    end else begin
      pop  = e_valid && id_ready;
      room = (q.size() < DEPTH) || pop;
      if (pop) q.delete(0);
      if (m_sync) begin
        e_br = 1; m_sync = 0;
      end else if (pc != cur) begin
        e_br = 1; m_sync = 1;
      end else begin
        e_req = room;
        if (room && imem_ready) begin
          q.push_back('{p: cur, w: imem_rdata});
          op = imem_rdata[31:26];
          if (op == 6'b000010) begin
            e_jump = 1;
            chk("jump_add", 32'(s_jump_add), 32'(imem_rdata[15:0]));
            m_exp = imem_rdata[15:0];
          end else if (op == 6'b000100 && cond_flag) begin
            tgt    = cur + 16'd4 + 16'(imem_rdata[15:0] * 4);
            e_br   = 1;
            e_badd = tgt;
            m_exp  = tgt;
          end else begin
            m_exp = cur + 16'd4;
          end
        end else begin
          e_br = 1;
        end
      end
    end
    chk("br", 32'(s_br), 32'(e_br));
    chk("jump", 32'(s_jump), 32'(e_jump));
    chk("br_jump_excl", 32'(s_br & s_jump), 32'h0);
    chk("imem_req", 32'(s_req), 32'(e_req));
    if (e_br)  chk("br_add", 32'(s_br_add), 32'(e_badd));
    if (e_req) chk("imem_addr", 32'(s_addr), 32'(cur));
  endtask

  // Sample at negedge, compare, then advance the bench PC register like a real PC.
  task automatic cycle();
    @(negedge clk);
    s_br = br; s_br_add = br_add; s_jump = jump; s_jump_add = jump_add;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr; s_ipc = instr_pc;
    model_step();
    @(posedge clk);
    #1;
    pc = s_br ? s_br_add : (s_jump ? s_jump_add : pc + 16'd4);
  endtask

  initial begin
    reset = 1; pc = 16'h1234; flush = 0; flush_add = 16'h0;
    imem_ready = 1; id_ready = 1; cond_flag = 0; imem_rdata = 32'h0;
    m_exp = 16'h0; m_sync = 1;

    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_br", 32'(s_br), 32'h1);
      chk("rst_br_add", 32'(s_br_add), 32'h0);
    end
    chk("pc_after_rst", 32'(pc), 32'h0);
    reset = 0;

    cycle(); chk("sync_req", 32'(s_req), 32'h0);
    cycle(); chk("seq_addr0", 32'(s_addr), 32'h0); chk("seq_br0", 32'(s_br), 32'h0);
    cycle(); chk("seq_addr4", 32'(s_addr), 32'h4); chk("seq_ipc0", 32'(s_ipc), 32'h0);
    imem_rdata = 32'h0800_0040;
    cycle(); chk("j_addr8", 32'(s_addr), 32'h8); chk("j_jump", 32'(s_jump), 32'h1);
    chk("j_target", 32'(s_jump_add), 32'h40);
    imem_rdata = 32'h0;
    cycle(); chk("j_next_addr", 32'(s_addr), 32'h40); chk("j_ipc8", 32'(s_ipc), 32'h8);

    flush = 1; flush_add = 16'h0010;
    cycle(); chk("fl10_br_add", 32'(s_br_add), 32'h10);
    flush = 0;
    cycle();
    imem_rdata = 32'h1000_FFFC; cond_flag = 1;
    cycle(); chk("beq_addr", 32'(s_addr), 32'h10); chk("beq_taken_add", 32'(s_br_add), 32'h4);
    imem_rdata = 32'h0; cond_flag = 0;
    cycle(); chk("beq_next", 32'(s_addr), 32'h4);

    flush = 1; cycle(); flush = 0; cycle();
    imem_rdata = 32'h1000_FFFC;
    cycle(); chk("beqnt_br", 32'(s_br), 32'h0);
    imem_rdata = 32'h0;
    cycle(); chk("beqnt_next", 32'(s_addr), 32'h14);

    flush = 1; flush_add = 16'h0020; id_ready = 0;
    cycle(); flush = 0; cycle();
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_br_add", 32'(s_br_add), 32'h20);
      chk("stall_pc", 32'(pc), 32'h20);
    end
    imem_ready = 1;
    cycle(); cycle();
    cycle(); chk("full_req", 32'(s_req), 32'h0); chk("full_hold", 32'(s_br_add), 32'h28);
    chk("full_ipc", 32'(s_ipc), 32'h20);
    id_ready = 1;
    cycle(); chk("resume_addr", 32'(s_addr), 32'h28); chk("resume_req", 32'(s_req), 32'h1);
    id_ready = 0;
    cycle();
    flush = 1; flush_add = 16'h0100;
    cycle(); chk("fl100_br_add", 32'(s_br_add), 32'h100);
    flush = 0;
    cycle(); chk("fl_valid_clr", 32'(s_valid), 32'h0); chk("fl_sync_req", 32'(s_req), 32'h0);
    cycle(); chk("fl_fetch", 32'(s_addr), 32'h100);
    pc = 16'h5555;
    cycle(); chk("mm_req", 32'(s_req), 32'h0); chk("mm_hold", 32'(s_br_add), 32'h104);
    cycle(); chk("mm_sync", 32'(s_req), 32'h0);
    cycle(); chk("mm_refetch", 32'(s_addr), 32'h104);

    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 24) == 0);
      flush_add  = 16'($urandom);
      imem_ready = ($urandom_range(0, 3) != 0);
      id_ready   = ($urandom_range(0, 2) != 0);
      cond_flag  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: imem_rdata = {6'b000010, 10'($urandom), 16'($urandom)};
        1: imem_rdata = {6'b000100, 10'($urandom), 16'($urandom)};
        default: imem_rdata = $urandom;
      endcase
      if ($urandom_range(0, 49) == 0) pc = 16'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch controller that sits on the other side of the program counter. It consumes `pc`, fetches from instruction memory, and partially decodes each fetched word. It drives the PC's `br`/`jump` steering inputs and target addresses so the free-running PC always matches the address the fetch side expects. Fetched words are buffered in a small FIFO and handed to decode with a valid/ready handshake.

Parameters:
FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.
INSTR_W, 32, instruction word width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
pc  input  16  current PC value.
br  output  1  PC steer: load br_add on the next edge.
br_add  output  16  branch/hold target.
jump  output  1  PC steer: load jump_add on the next edge.
jump_add  output  16  jump target.
imem_req  output  1  fetch request.
imem_addr  output  16  fetch address.
imem_ready  input  1  imem_rdata valid this cycle; single-cycle, combinational.
imem_rdata  input  INSTR_W  fetched word.
cond_flag  input  1  branch condition, sampled in the fetch cycle.
flush  input  1  pipeline redirect request, one-cycle pulse.
flush_add  input  16  redirect target.
instr_valid  output  1  FIFO head valid.
instr  output  INSTR_W  FIFO head word.
instr_pc  output  16  address of the FIFO head.
id_ready  input  1  decode accepts the head.

Behaviour:
- Registered state:
  - `exp_pc`: expected PC, 16 bits.
  - FSM state: SYNC or RUN.
  - FIFO of {pc, word}, with count.
- Reset (reset=1 at posedge):
  - exp_pc=0, FIFO empty, state=SYNC.
  - While reset is high: br=1, br_add=0, jump=0, imem_req=0, instr_valid=0. This forces the PC to 0 on the same edge.
- br and jump are never both 1. PC encoding 2'b11 is illegal.
- Outputs are combinational from state and inputs, so the PC samples them on the same edge.
- SYNC:
  - imem_req=0, br=1, br_add=exp_pc.
  - Next state is RUN.
- RUN, mismatch (pc != exp_pc):
  - No fetch; br=1, br_add=exp_pc.
  - Next state is SYNC.
- RUN, pc == exp_pc:
  - imem_req=1 and imem_addr=exp_pc when a push is possible.
  - A push is possible when count<FIFO_DEPTH, or when the FIFO is full and popping this cycle.
- Accept condition: imem_req & imem_ready. On accept:
  - Push {exp_pc, imem_rdata}.
  - Decode opcode = imem_rdata[31:26]:
    - 6'b000010 (J): jump=1, jump_add=imem_rdata[15:0]; exp_pc <= jump_add.
    - 6'b000100 (BEQ) with cond_flag=1: br=1, br_add=exp_pc+4+(imm16<<2), 16-bit wrap; exp_pc <= br_add.
    - Otherwise: br=jump=0; exp_pc <= exp_pc+4, 16-bit wrap (0xFFFC -> 0x0000).
- No accept in RUN (imem_ready=0 or no push possible):
  - br=1, br_add=exp_pc, so the PC holds.
  - No word is lost or duplicated.
- Flush, highest priority over everything except reset:
  - br=1, br_add=flush_add, jump=0.
  - FIFO cleared; exp_pc <= flush_add; state <= SYNC.
  - Any same-cycle fetch is discarded and any same-cycle pop is ignored.
- FIFO:
  - Pop when instr_valid & id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Head outputs are stable while instr_valid=1 and id_ready=0.
- Latency: a word accepted at edge N is visible on instr at cycle N+1 if the FIFO was empty.

Optional Feature:
IFETCH_PERF_EN
- Defined: adds outputs `stall_cnt[15:0]`, `redirect_cnt[15:0]` and `flush_cnt[15:0]`, all cleared by reset and saturating at 0xFFFF.
  - stall_cnt counts RUN cycles with a hold br.
  - redirect_cnt counts taken J/BEQ.
  - flush_cnt counts flushes.
- Undefined: the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset held 3 cycles with pc at random 0x1234:
  - br=1, br_add=0 throughout; pc=0 after release.
  - First imem_addr=0x0000 one cycle later (SYNC).
- Sequential fetch, imem_ready=1, id_ready=1, non-branch words:
  - imem_addr goes 0,4,8,C.
  - instr_pc follows one cycle later; br=jump=0 throughout.
- J with imem_rdata=0x0800_0040 fetched at 0x0008:
  - jump=1 for one cycle, jump_add=0x0040.
  - Next fetch address 0x0040; FIFO holds 0x0008.
- BEQ at 0x0010, imm16=0xFFFC:
  - cond_flag=1: br_add=0x0004.
  - cond_flag=0: next fetch 0x0014.
- imem_ready=0 for 3 cycles at exp_pc 0x0020:
  - br=1, br_add=0x0020 each cycle; pc stays 0x0020.
  - Word is pushed exactly once.
  - With id_ready=0 and the FIFO full: hold until a pop, then fetch resumes.
- flush with flush_add=0x0100 while FIFO holds 2 entries:
  - br_add=0x0100, instr_valid=0 next cycle.
  - SYNC one cycle, then fetch 0x0100; forcing pc mismatch also yields a hold plus SYNC.
